// File: rtl/mem_access_unit.sv
// Load/store unit between the decode/execute path and an SRAM-like data bus.
// Takes one memory operation at a time, checks alignment, issues a single bus
// transaction and returns a one-cycle writeback result.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   req_valid/req_ready   upstream handshake (ready only when idle)
//   mem_read, mem_write   load / store request
//   size_mem              0 = byte, 1 = half, 2 = word
//   is_unsign_load        zero-extend sub-word loads
//   addr, store_data, rd  effective address, store operand, destination reg
//   flush                 cancels the in-flight operation
//   data_*                SRAM-like bus request / response
//   resp_*                one-cycle writeback result
//   ale, badv             alignment exception and faulting address
module mem_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size_mem,
  input  logic        is_unsign_load,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        ale,
  output logic [31:0] badv
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StCancel, StResp} state_e;

  state_e      state_q, state_d;
  logic        read_q, write_q, unsign_q, ale_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, sdata_q, rdata_q;
  logic [4:0]  rd_q;

  logic        accept, capture, misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;

  assign accept  = (state_q == StIdle) && req_valid && !flush;
  assign capture = (state_q == StWait) && data_data_ok && !flush;

  always_comb begin
    misaligned = 1'b0;
    case (size_mem)
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          state_d = (misaligned || !(mem_read || mem_write)) ? StResp : StReq;
        end
      end
      StReq: begin
        // An accepted address owes us a data beat, so a flush must drain it.
        if (data_addr_ok)  state_d = flush ? StCancel : StWait;
        else if (flush)    state_d = StIdle;
      end
      StWait: begin
        if (flush)             state_d = data_data_ok ? StIdle : StCancel;
        else if (data_data_ok) state_d = StResp;
      end
      StCancel: begin
        if (data_data_ok) state_d = StIdle;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      unsign_q <= 1'b0;
      ale_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      sdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      if (accept) begin
        read_q   <= mem_read;
        write_q  <= mem_write;
        unsign_q <= is_unsign_load;
        ale_q    <= misaligned;
        size_q   <= size_mem;
        addr_q   <= addr;
        sdata_q  <= store_data;
        rd_q     <= rd;
      end
      if (capture) begin
        rdata_q <= data_rdata;
      end
    end
  end

  // Bus request: fields come straight from latched state, so they stay stable
  // for as long as the slave withholds data_addr_ok.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'd0;
    data_wstrb = 4'd0;
    data_wdata = 32'd0;
    if (state_q == StReq) begin
      data_req  = 1'b1;
      data_wr   = write_q;
      data_size = size_q;
      data_addr = addr_q;
      unique case (size_q)
        2'd0: begin
          data_wstrb = 4'b0001 << addr_q[1:0];
          data_wdata = {4{sdata_q[7:0]}};
        end
        2'd1: begin
          data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{sdata_q[15:0]}};
        end
        2'd2: begin
          data_wstrb = 4'b1111;
          data_wdata = sdata_q;
        end
        default: begin
          data_wstrb = 4'd0;
          data_wdata = 32'd0;
        end
      endcase
      if (!write_q) data_wstrb = 4'd0;
    end
  end

  always_comb begin
    byte_sel    = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel    = rdata_q[{addr_q[1], 4'b0000} +: 16];
    load_result = 32'd0;
    case (size_q)
      2'd0:    load_result = {{24{~unsign_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_result = {{16{~unsign_q & half_sel[15]}}, half_sel};
      2'd2:    load_result = rdata_q;
      default: load_result = 32'd0;
    endcase
  end

  // A flush landing in RESP kills the writeback combinationally.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = 1'b0;
    resp_we    = 1'b0;
    resp_rd    = 5'd0;
    resp_data  = 32'd0;
    ale        = 1'b0;
    badv       = 32'd0;
    if ((state_q == StResp) && !flush) begin
      resp_valid = 1'b1;
      resp_we    = read_q && !ale_q;
      resp_rd    = rd_q;
      resp_data  = (read_q && !ale_q) ? load_result : 32'd0;
      ale        = ale_q;
      badv       = ale_q ? addr_q : 32'd0;
    end
  end

endmodule
